// File: rtl/aes_encipher_core_p.sv
// aes_encipher_core_p: AES encipher datapath with SBOX_LANES-wide external S-box interface.
// Define AES_ENC_KEY256_EN to enable 14-round AES-256 selection via keylen.
module aes_encipher_core_p #(
    parameter int SBOX_LANES = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    next,
    input  logic                    keylen,
    input  logic [127:0]            round_key,
    input  logic [127:0]            block,
    input  logic [32*SBOX_LANES-1:0] new_sbox,
    output logic [32*SBOX_LANES-1:0] sbox,
    output logic [3:0]              round,
    output logic [127:0]            new_block,
    output logic                    ready,
    output logic                    done
);
    localparam int S = 4 / SBOX_LANES;
    localparam int W = 32 * SBOX_LANES;
    localparam logic [1:0] LAST = 2'(S - 1);

    typedef enum logic [1:0] {IDLE, INIT, SBOX, MAIN} state_t;
    state_t state, state_nxt;
    logic [1:0] word_ctr;
    logic [3:0] nr;
    logic [6:0] hi;
    logic last_round;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_word(input logic [31:0] w);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = w;
        return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        return {mix_word(s[127:96]), mix_word(s[95:64]), mix_word(s[63:32]), mix_word(s[31:0])};
    endfunction

    // Row r of column c takes the byte from column (c+r) mod 4.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127 - 8 * (4 * c + r) -: 8] = s[127 - 8 * (4 * ((c + r) % 4) + r) -: 8];
        return o;
    endfunction

    assign hi         = 7'(127 - W * int'(word_ctr));
    assign last_round = (round == nr);
    assign sbox       = (state == SBOX) ? new_block[hi -: W] : '0;

`ifdef AES_ENC_KEY256_EN
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n)
            nr <= 4'd10;
        else if (state == IDLE && next)
            nr <= keylen ? 4'd14 : 4'd10;
`else
    logic unused_keylen;
    assign unused_keylen = keylen;
    assign nr = 4'd10;
`endif

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = next ? INIT : IDLE;
            INIT:    state_nxt = SBOX;
            SBOX:    state_nxt = (word_ctr == LAST) ? MAIN : SBOX;
            MAIN:    state_nxt = last_round ? IDLE : SBOX;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            new_block <= '0;
            round     <= '0;
            word_ctr  <= '0;
            ready     <= 1'b1;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (next) begin
                    round <= '0;
                    ready <= 1'b0;
                end
                INIT: begin
                    new_block <= block ^ round_key;
                    round     <= 4'd1;
                    word_ctr  <= '0;
                end
                SBOX: begin
                    new_block[hi -: W] <= new_sbox;
                    word_ctr <= (word_ctr == LAST) ? 2'd0 : word_ctr + 2'd1;
                end
                MAIN: if (last_round) begin
                    new_block <= shift_rows(new_block) ^ round_key;
                    ready     <= 1'b1;
                    done      <= 1'b1;
                end else begin
                    new_block <= mix_columns(shift_rows(new_block)) ^ round_key;
                    round     <= round + 4'd1;
                end
                default: ;
            endcase
        end
endmodule

// File: tb/tb_aes_encipher_core_p.sv
// tb_aes_encipher_core_p: directed FIPS-197 checks on 1-lane and 4-lane cores sharing stimulus.
// Bench S-box and key schedule are computed from GF(2^8) arithmetic, not tabulated.
module tb_aes_encipher_core_p;
    localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K128  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [255:0] K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic clk = 0, reset_n = 1, next = 0, keylen = 0;
    logic [127:0] block = '0;
    logic [127:0] rk [0:15];
    logic [127:0] rk1, rk2, nb1, nb2, sb2, nsb2;
    logic [31:0] sb1, nsb1;
    logic [3:0] rnd1, rnd2;
    logic rdy1, rdy2, dn1, dn2;
    int total = 0, bad = 0;
    int c1, c2, n1, n2, nz2, first, second;

    always #5 clk = ~clk;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 0;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p ^= a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sub_byte(input logic [7:0] x);
        logic [7:0] r = 8'h01, t, s;
        logic [7:0] e = 8'd254;
        for (int i = 7; i >= 0; i--) begin
            r = gmul(r, r);
            if (e[i]) r = gmul(r, x);
        end
        t = r;
        s = r;
        for (int n = 0; n < 4; n++) begin
            t = {t[6:0], t[7]};
            s ^= t;
        end
        return s ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sub_byte(w[31:24]), sub_byte(w[23:16]), sub_byte(w[15:8]), sub_byte(w[7:0])};
    endfunction

    assign rk1  = rk[rnd1];
    assign rk2  = rk[rnd2];
    assign nsb1 = sub_word(sb1);
    assign nsb2 = {sub_word(sb2[127:96]), sub_word(sb2[95:64]), sub_word(sb2[63:32]), sub_word(sb2[31:0])};

    aes_encipher_core_p #(.SBOX_LANES(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .next(next), .keylen(keylen), .round_key(rk1),
        .block(block), .new_sbox(nsb1), .sbox(sb1), .round(rnd1), .new_block(nb1),
        .ready(rdy1), .done(dn1));

    aes_encipher_core_p #(.SBOX_LANES(4)) dut2 (
        .clk(clk), .reset_n(reset_n), .next(next), .keylen(keylen), .round_key(rk2),
        .block(block), .new_sbox(nsb2), .sbox(sb2), .round(rnd2), .new_block(nb2),
        .ready(rdy2), .done(dn2));

    task automatic expand(input logic [255:0] key, input int nk);
        logic [31:0] w [0:59];
        logic [31:0] t;
        logic [7:0] rcon = 8'h01;
        int nr = nk + 6;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32 * i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = w[i - 1];
            if (i % nk == 0) begin
                t = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = xt(rcon);
            end else if (nk > 6 && i % nk == 4)
                t = sub_word(t);
            w[i] = w[i - nk] ^ t;
        end
        for (int r = 0; r < 16; r++)
            rk[r] = (r <= nr) ? {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]} : '0;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Starts one operation and samples both cores for ncyc edges; a second next
    // with a different block is pulsed after edge rep while the cores are busy.
    task automatic run_op(input logic [127:0] blk, input logic kl, input int ncyc, input int rep);
        @(negedge clk);
        block = blk;
        keylen = kl;
        next = 1;
        @(posedge clk);
        #1 next = 0;
        keylen = ~kl;
        c1 = 0; c2 = 0; n1 = 0; n2 = 0; nz2 = 0;
        for (int i = 1; i <= ncyc; i++) begin
            @(posedge clk);
            #1;
            if (dn1) begin n1++; if (c1 == 0) c1 = i; end
            if (dn2) begin n2++; if (c2 == 0) c2 = i; end
            if (sb2 != 0) nz2++;
            if (i == rep) begin next = 1; block = ~blk; end
            if (i == rep + 1) begin next = 0; block = blk; end
        end
    endtask

    initial begin
        expand({K128, 128'h0}, 4);
        #2 reset_n = 0;
        #1;
        chk("rst_ready", 128'(rdy1), 128'(1));
        chk("rst_done", 128'(dn1), 128'(0));
        chk("rst_block", nb1, '0);
        chk("rst_round", 128'(rnd1), 128'(0));
        chk("rst_sbox", 128'(sb1), 128'(0));
        chk("rst_ready4", 128'(rdy2), 128'(1));
        @(negedge clk) reset_n = 1;

        run_op(PT, 0, 80, 0);
        chk("a128_lat", 128'(c1), 128'(51));
        chk("a128_ndone", 128'(n1), 128'(1));
        chk("a128_ct", nb1, CT128);
        chk("a128_round", 128'(rnd1), 128'(10));
        chk("a128_ready", 128'(rdy1), 128'(1));
        chk("a128_sbox_idle", 128'(sb1), 128'(0));
        chk("l4_lat", 128'(c2), 128'(21));
        chk("l4_ct", nb2, CT128);
        chk("l4_sbox_cycles", 128'(nz2), 128'(10));

        run_op(PT, 0, 80, 20);
        chk("rep_lat", 128'(c1), 128'(51));
        chk("rep_ndone", 128'(n1), 128'(1));
        chk("rep_ct", nb1, CT128);
        chk("rep_ndone4", 128'(n2), 128'(1));
        chk("rep_ct4", nb2, CT128);

`ifdef AES_ENC_KEY256_EN
        expand(K256, 8);
        run_op(PT, 1, 90, 0);
        chk("a256_lat", 128'(c1), 128'(71));
        chk("a256_ct", nb1, CT256);
        chk("a256_round", 128'(rnd1), 128'(14));
        chk("a256_lat4", 128'(c2), 128'(29));
        chk("a256_ct4", nb2, CT256);
        expand({K128, 128'h0}, 4);
`else
        run_op(PT, 1, 80, 0);
        chk("kl1_lat", 128'(c1), 128'(51));
        chk("kl1_ct", nb1, CT128);
        chk("kl1_round", 128'(rnd1), 128'(10));
`endif

        @(negedge clk);
        block = PT;
        keylen = 0;
        next = 1;
        @(posedge clk);
        #1 next = 0;
        repeat (30) @(posedge clk);
        #2 reset_n = 0;
        #1;
        chk("mid_rst_block", nb1, '0);
        chk("mid_rst_round", 128'(rnd1), 128'(0));
        chk("mid_rst_ready", 128'(rdy1), 128'(1));
        chk("mid_rst_done", 128'(dn1), 128'(0));
        chk("mid_rst_sbox", 128'(sb1), 128'(0));
        chk("mid_rst_sbox4", sb2, '0);
        @(negedge clk) reset_n = 1;
        run_op(PT, 0, 80, 0);
        chk("post_rst_lat", 128'(c1), 128'(51));
        chk("post_rst_ct", nb1, CT128);

        @(negedge clk);
        block = PT;
        keylen = 0;
        next = 1;
        @(posedge clk);
        first = 0;
        second = 0;
        for (int i = 1; i <= 110; i++) begin
            @(posedge clk);
            #1;
            if (dn1) begin
                if (first == 0) first = i;
                else if (second == 0) second = i;
            end
        end
        next = 0;
        chk("b2b_first", 128'(first), 128'(51));
        chk("b2b_gap", 128'(second - first), 128'(52));
        @(negedge clk) reset_n = 0;
        @(negedge clk) reset_n = 1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
